serial_transition_monitor: RTL and testbench
============================================

Name: serial_transition_monitor

Overview:
Windowed controller around a per-channel serial transition detector (z = current sample XOR previous sample). On start it arms N_CH serial channels and counts per-channel transitions over a fixed window of WIN_LEN cycles. It then flags channels whose count reaches a threshold. Finally it drains the per-channel counts, one channel per transfer, over a valid/ready result port. It sits between raw serial line inputs and a host/status collector.

Parameters:
N_CH, 4, number of serial input channels
CNT_W, 8, width of each per-channel transition counter
WIN_LEN, 16, number of comparison cycles per window (>=1)
CH_W, $clog2(N_CH) (min 1), width of channel index

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin a window; honoured only in IDLE
abort  in  1  cancel the current operation; returns to IDLE
x  in  N_CH  serial inputs, one bit per channel
thresh  in  CNT_W  alarm threshold, sampled in ARM
busy  out  1  high in ARM, RUN and DRAIN
z  out  N_CH  registered per-channel transition flag
done  out  1  one-cycle pulse at window completion
alarm  out  N_CH  latched per-channel flag, set when cnt >= threshold at window end
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_ch  out  CH_W  channel index of current result
res_cnt  out  CNT_W  transition count of res_ch

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; z, done, alarm, res_valid, res_ch, res_cnt, busy all 0; counters, prev-sample register, window counter and threshold register cleared.
- FSM states: IDLE, ARM, RUN, DRAIN.
- IDLE: start=1 -> ARM. If start and abort are both high, abort wins and the FSM stays in IDLE.
- ARM (exactly 1 cycle):
  - prev <= x; cnt[i] <= 0; win <= 0; thr <= thresh.
  - No comparison this cycle; z stays 0.
  - -> RUN.
- RUN, each cycle:
  - z[i] <= x[i] ^ prev[i]; prev <= x.
  - cnt[i] <= cnt[i] + (x[i]^prev[i]), saturating at 2^CNT_W-1 (no wrap).
  - win <= win+1. On the WIN_LEN-th RUN cycle -> DRAIN.
- Entry to DRAIN:
  - done=1 for exactly that first DRAIN cycle.
  - alarm[i] <= (final cnt[i] >= thr), registered together with done.
  - z cleared to 0 on leaving RUN.
- Latency: start sampled at edge k -> ARM cycle k+1 -> RUN cycles k+2..k+1+WIN_LEN -> done high in cycle k+2+WIN_LEN.
- DRAIN:
  - res_valid=1 from the first DRAIN cycle; res_ch starts at 0; res_cnt = cnt[res_ch].
  - Transfer occurs when res_valid && res_ready at a rising edge; res_ch then increments.
  - While res_valid && !res_ready, res_ch and res_cnt are held stable.
  - After the transfer of channel N_CH-1 -> IDLE; res_valid is 0 in the next cycle.
- start is ignored in ARM, RUN and DRAIN.
- abort=1 in ARM, RUN or DRAIN -> IDLE at the next edge:
  - res_valid, z and busy drop.
  - No done pulse; alarm keeps its previous value.
  - Counts are not drained.
- alarm holds until the next window completes or reset. thresh=0 -> all alarm bits set at window end.
- The next start from IDLE fully re-arms; no residue from earlier windows.

Test Plan:
1. N_CH=4, WIN_LEN=16, thresh=5:
   - Stimulus: ch0 held 0, ch1 toggles every cycle, ch2 toggles on RUN cycles 4,8,12,16, ch3 held 1.
   - Required: done exactly 18 cycles after the start edge; drained (ch,cnt) = (0,0), (1,16), (2,4), (3,0); alarm=4'b0010.
2. CNT_W=4, WIN_LEN=20, ch1 toggles every cycle -> res_cnt for ch1 = 15 (saturated, not 4).
3. Backpressure:
   - Stimulus: res_ready low for 3 DRAIN cycles, then alternating 1/0.
   - Required: res_ch/res_cnt unchanged while not ready; exactly 4 transfers in order 0..3; busy=0 the cycle after the last transfer.
4. abort asserted on RUN cycle 5:
   - Required: IDLE next cycle, no done, res_valid never asserted, alarm unchanged.
   - A following start with all channels static yields all counts 0.
5. rst asserted mid-DRAIN between clock edges -> res_valid, busy, alarm drop to 0 immediately, without waiting for a clock edge.
6. start pulsed during RUN and during DRAIN -> ignored (window length and drain order unchanged). start+abort together in IDLE -> remains IDLE, busy stays 0.

Source files
------------

// File: rtl/serial_transition_monitor_if.sv
// Result drain port of the serial transition monitor: one channel count per
// valid/ready transfer.
interface serial_transition_monitor_if #(
    parameter int CNT_W = 8,
    parameter int CH_W  = 2
);
    logic             res_valid;
    logic             res_ready;
    logic [CH_W-1:0]  res_ch;
    logic [CNT_W-1:0] res_cnt;

    modport master (output res_valid, res_ch, res_cnt, input res_ready);
    modport slave  (input res_valid, res_ch, res_cnt, output res_ready);
endinterface

// File: rtl/serial_transition_monitor.sv
// Windowed per-channel transition counter: arm, count x^prev over WIN_LEN
// cycles, flag channels at or above threshold, then drain counts one by one.
module serial_transition_monitor #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 16,
    parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_CH-1:0]  x,
    input  logic [CNT_W-1:0] thresh,
    output logic             busy,
    output logic [N_CH-1:0]  z,
    output logic             done,
    output logic [N_CH-1:0]  alarm,
    serial_transition_monitor_if.master res
);
    localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    state_t           state;
    logic [N_CH-1:0]  prev;
    logic [WIN_W-1:0] win;
    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] cnt     [N_CH];
    logic [CNT_W-1:0] cnt_nxt [N_CH];
    logic [N_CH-1:0]  diff;
    logic [N_CH-1:0]  alarm_nxt;
    logic [CH_W-1:0]  ch_nxt;
    logic             last_ch;
    logic             last_win;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic inc);
        if (inc && (c != {CNT_W{1'b1}}))
            return c + CNT_W'(1);
        return c;
    endfunction

    assign diff     = x ^ prev;
    assign ch_nxt   = res.res_ch + CH_W'(1);
    assign last_ch  = (res.res_ch == CH_W'(N_CH - 1));
    assign last_win = (win == WIN_W'(WIN_LEN - 1));

    always_comb begin
        alarm_nxt = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt[i]   = sat_inc(cnt[i], diff[i]);
            alarm_nxt[i] = (cnt_nxt[i] >= thr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            z             <= '0;
            done          <= 1'b0;
            alarm         <= '0;
            res.res_valid <= 1'b0;
            res.res_ch    <= '0;
            res.res_cnt   <= '0;
            prev          <= '0;
            win           <= '0;
            thr           <= '0;
            for (int i = 0; i < N_CH; i++)
                cnt[i] <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                // Abort discards the window: no done, no drain, alarm untouched.
                state         <= IDLE;
                busy          <= 1'b0;
                z             <= '0;
                res.res_valid <= 1'b0;
                res.res_ch    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state <= ARM;
                            busy  <= 1'b1;
                        end
                    end
                    ARM: begin
                        prev  <= x;
                        win   <= '0;
                        thr   <= thresh;
                        state <= RUN;
                        for (int i = 0; i < N_CH; i++)
                            cnt[i] <= '0;
                    end
                    RUN: begin
                        prev <= x;
                        for (int i = 0; i < N_CH; i++)
                            cnt[i] <= cnt_nxt[i];
                        if (last_win) begin
                            // Final comparison feeds alarm and first result directly.
                            state         <= DRAIN;
                            done          <= 1'b1;
                            alarm         <= alarm_nxt;
                            z             <= '0;
                            res.res_valid <= 1'b1;
                            res.res_ch    <= '0;
                            res.res_cnt   <= cnt_nxt[0];
                        end else begin
                            z   <= diff;
                            win <= win + WIN_W'(1);
                        end
                    end
                    DRAIN: begin
                        if (res.res_ready) begin
                            if (last_ch) begin
                                state         <= IDLE;
                                busy          <= 1'b0;
                                res.res_valid <= 1'b0;
                                res.res_ch    <= '0;
                            end else begin
                                res.res_ch  <= ch_nxt;
                                res.res_cnt <= cnt[ch_nxt];
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_transition_monitor.sv
// Randomized bench for serial_transition_monitor with a sample-history
// reference model; a second instance covers a narrow saturating counter.
module tb_serial_transition_monitor;
    localparam int N_CH      = 4;
    localparam int CNT_W     = 8;
    localparam int WIN_LEN   = 16;
    localparam int CNT_W_B   = 4;
    localparam int WIN_LEN_B = 20;
    localparam int CH_W      = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               start, abort, start_b;
    logic [N_CH-1:0]    x;
    logic [CNT_W-1:0]   thresh;
    logic [CNT_W_B-1:0] thresh_b;
    logic               busy, done, busy_b, done_b;
    logic [N_CH-1:0]    z, alarm, z_b, alarm_b;

    int total = 0;
    int bad   = 0;

    logic [N_CH-1:0] xs [0:31];
    logic [N_CH-1:0] alarm_m;

    serial_transition_monitor_if #(.CNT_W(CNT_W),   .CH_W(CH_W)) ra ();
    serial_transition_monitor_if #(.CNT_W(CNT_W_B), .CH_W(CH_W)) rb ();

    serial_transition_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_LEN(WIN_LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .x(x), .thresh(thresh),
        .busy(busy), .z(z), .done(done), .alarm(alarm), .res(ra.master)
    );

    serial_transition_monitor #(.N_CH(N_CH), .CNT_W(CNT_W_B), .WIN_LEN(WIN_LEN_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(1'b0), .x(x), .thresh(thresh_b),
        .busy(busy_b), .z(z_b), .done(done_b), .alarm(alarm_b), .res(rb.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_CH-1:0] gen(input int pat, input int j);
        logic [N_CH-1:0] v;
        case (pat)
            0: begin
                v    = '0;
                v[1] = j[0];
                v[2] = j[2];
                v[3] = 1'b1;
            end
            1: v = 4'b1010;
            3: begin
                v    = N_CH'($urandom);
                v[1] = j[0];
            end
            default: v = N_CH'($urandom);
        endcase
        return v;
    endfunction

    // Transitions seen in the recorded sample history, clipped at maxv.
    function automatic int exp_cnt(input int ch, input int wl, input int maxv);
        int n = 0;
        for (int j = 1; j <= wl; j++)
            if (xs[j][ch] !== xs[j-1][ch]) n++;
        return (n > maxv) ? maxv : n;
    endfunction

    // abort_at: -1 none, 0 in ARM, 1..WIN_LEN RUN cycle, >WIN_LEN drain cycle.
    // rmode: 0 always ready, 1 three low then alternating, 2 random, 3 reset mid-drain.
    task automatic run_window(input int pat, input logic [CNT_W-1:0] th, input int abort_at,
                              input int rmode, input bit noise);
        int ec [N_CH];
        int ch;
        logic rdy;
        logic [N_CH-1:0] al_before;
        al_before = alarm_m;
        thresh = th;
        xs[0]  = gen(pat, 0);
        x      = xs[0];
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_z", 32'(z), 32'd0);
        if (abort_at == 0) abort = 1'b1;
        tick();
        if (abort_at == 0) begin
            abort = 1'b0;
            chk("abort_arm_busy", 32'(busy), 32'd0);
            chk("abort_arm_alarm", 32'(alarm), 32'(al_before));
            return;
        end
        for (int j = 1; j <= WIN_LEN; j++) begin
            xs[j] = gen(pat, j);
            x     = xs[j];
            start = noise ? 1'($urandom) : 1'b0;
            if (abort_at == j) abort = 1'b1;
            tick();
            start = 1'b0;
            if (abort_at == j) begin
                abort = 1'b0;
                chk("abort_run_busy", 32'(busy), 32'd0);
                chk("abort_run_valid", 32'(ra.res_valid), 32'd0);
                chk("abort_run_done", 32'(done), 32'd0);
                chk("abort_run_z", 32'(z), 32'd0);
                chk("abort_run_alarm", 32'(alarm), 32'(al_before));
                tick();
                chk("abort_run_idle", 32'(busy), 32'd0);
                chk("abort_run_novalid", 32'(ra.res_valid), 32'd0);
                return;
            end
            chk("run_z", 32'(z), (j < WIN_LEN) ? 32'(xs[j] ^ xs[j-1]) : 32'd0);
            chk("run_done", 32'(done), 32'(j == WIN_LEN));
            chk("run_busy", 32'(busy), 32'd1);
        end
        for (int i = 0; i < N_CH; i++) begin
            ec[i]      = exp_cnt(i, WIN_LEN, (1 << CNT_W) - 1);
            alarm_m[i] = (ec[i] >= int'(th));
        end
        chk("alarm", 32'(alarm), 32'(alarm_m));
        ch = 0;
        for (int cyc = 0; cyc < 100 && ch < N_CH; cyc++) begin
            chk("drain_valid", 32'(ra.res_valid), 32'd1);
            chk("drain_ch", 32'(ra.res_ch), 32'(ch));
            chk("drain_cnt", 32'(ra.res_cnt), 32'(ec[ch]));
            if (cyc > 0) chk("drain_done_low", 32'(done), 32'd0);
            if (abort_at == WIN_LEN + 1 + cyc) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("abort_drain_valid", 32'(ra.res_valid), 32'd0);
                chk("abort_drain_busy", 32'(busy), 32'd0);
                chk("abort_drain_alarm", 32'(alarm), 32'(alarm_m));
                return;
            end
            if (rmode == 3 && cyc == 2) begin
                ra.res_ready = 1'b0;
                #1;
                rst = 1'b1;
                #2;
                chk("rst_valid", 32'(ra.res_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_alarm", 32'(alarm), 32'd0);
                chk("rst_ch", 32'(ra.res_ch), 32'd0);
                alarm_m = '0;
                #2;
                rst = 1'b0;
                tick();
                chk("rst_idle", 32'(busy), 32'd0);
                return;
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc < 3) ? 1'b0 : (((cyc - 3) % 2) == 0);
                default: rdy = 1'($urandom);
            endcase
            ra.res_ready = rdy;
            start = noise ? 1'($urandom) : 1'b0;
            tick();
            start = 1'b0;
            if (rdy) ch++;
        end
        ra.res_ready = 1'b0;
        chk("drain_transfers", 32'(ch), 32'(N_CH));
        chk("post_drain_valid", 32'(ra.res_valid), 32'd0);
        chk("post_drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_b();
        int ch;
        int ecb [N_CH];
        thresh_b = 4'd3;
        xs[0]    = gen(3, 0);
        x        = xs[0];
        start_b  = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        for (int j = 1; j <= WIN_LEN_B; j++) begin
            xs[j] = gen(3, j);
            x     = xs[j];
            tick();
            chk("b_done", 32'(done_b), 32'(j == WIN_LEN_B));
        end
        for (int i = 0; i < N_CH; i++)
            ecb[i] = exp_cnt(i, WIN_LEN_B, (1 << CNT_W_B) - 1);
        chk("b_sat_ch1", 32'(ecb[1]), 32'd15);
        chk("b_alarm1", 32'(alarm_b[1]), 32'd1);
        rb.res_ready = 1'b1;
        ch = 0;
        for (int cyc = 0; cyc < 20 && ch < N_CH; cyc++) begin
            chk("b_valid", 32'(rb.res_valid), 32'd1);
            chk("b_ch", 32'(rb.res_ch), 32'(ch));
            chk("b_cnt", 32'(rb.res_cnt), 32'(ecb[ch]));
            tick();
            ch++;
        end
        rb.res_ready = 1'b0;
        chk("b_busy_end", 32'(busy_b), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; start_b = 1'b0;
        x = '0; thresh = '0; thresh_b = '0;
        ra.res_ready = 1'b0; rb.res_ready = 1'b0;
        alarm_m = '0;
        tick();
        tick();
        chk("rst_busy0", 32'(busy), 32'd0);
        chk("rst_z0", 32'(z), 32'd0);
        chk("rst_done0", 32'(done), 32'd0);
        chk("rst_alarm0", 32'(alarm), 32'd0);
        chk("rst_valid0", 32'(ra.res_valid), 32'd0);
        chk("rst_ch0", 32'(ra.res_ch), 32'd0);
        chk("rst_cnt0", 32'(ra.res_cnt), 32'd0);
        chk("rst_busy_b0", 32'(busy_b), 32'd0);
        rst = 1'b0;
        tick();

        run_window(0, 8'd5, -1, 0, 1'b0);
        chk("tp1_alarm", 32'(alarm), 32'(4'b0010));
        run_window(2, 8'($urandom_range(0, 12)), -1, 1, 1'b0);
        run_window(2, 8'd3, 5, 0, 1'b0);
        run_window(1, 8'd0, -1, 0, 1'b0);
        run_window(2, 8'($urandom_range(0, 12)), -1, 2, 1'b1);

        start = 1'b1; abort = 1'b1;
        tick();
        chk("start_abort_idle", 32'(busy), 32'd0);
        start = 1'b0; abort = 1'b0;
        tick();
        chk("start_abort_idle2", 32'(busy), 32'd0);

        run_window(2, 8'd2, 0, 0, 1'b0);
        run_window(2, 8'd4, WIN_LEN + 3, 1, 1'b0);
        run_window(2, 8'd0, -1, 3, 1'b0);
        repeat (6) run_window(2, 8'($urandom_range(0, 12)), -1, 2, 1'b1);
        run_b();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
